// File: rtl/cpu_pipe.sv
// Three-stage (fetch / execute / writeback) pipelined CPU core with writeback
// forwarding, hard-wired r0, global stall enable, sticky HALT and debug read port.
module cpu_pipe #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_ins,
   output logic              halted,
   output logic              wb_valid,
   output logic [2:0]        wb_reg,
   output logic [DATA_W-1:0] wb_data,
   input  logic [2:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int SH_W = $clog2(DATA_W);

   localparam logic [6:0] OP_ADD  = 7'd1;
   localparam logic [6:0] OP_SUB  = 7'd2;
   localparam logic [6:0] OP_AND  = 7'd3;
   localparam logic [6:0] OP_OR   = 7'd4;
   localparam logic [6:0] OP_XOR  = 7'd5;
   localparam logic [6:0] OP_SLL  = 7'd6;
   localparam logic [6:0] OP_SRL  = 7'd7;
   localparam logic [6:0] OP_LDI  = 7'd8;
   localparam logic [6:0] OP_HALT = 7'h7F;

   logic [PC_W-1:0]   pc_reg;
   logic [15:0]       ifex_ins_reg;
   logic              exwb_valid_reg;
   logic [2:0]        exwb_reg_reg;
   logic [DATA_W-1:0] exwb_data_reg;
   logic              halted_reg;
   logic [DATA_W-1:0] regs_reg [8];

   logic [6:0]        ex_op;
   logic [2:0]        ex_rd;
   logic              ex_is_halt;
   logic [DATA_W-1:0] alu_res;
   logic              alu_wr;
   logic              exwb_valid_next;

   assign ex_op      = ifex_ins_reg[15:9];
   assign ex_rd      = ifex_ins_reg[2:0];
   assign ex_is_halt = (ex_op == OP_HALT);

   // Operand 0 is rs1, operand 1 is rs2; a live writeback to the same
   // non-zero register overrides the regfile value.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         logic [2:0]        sel;
         logic [DATA_W-1:0] val;
         assign sel = (gi == 0) ? ifex_ins_reg[8:6] : ifex_ins_reg[5:3];
         assign val = (sel == 3'd0) ? '0 :
                      (exwb_valid_reg && (exwb_reg_reg == sel)) ? exwb_data_reg :
                      regs_reg[sel];
      end
   endgenerate

   always_comb begin
      alu_res = '0;
      alu_wr  = 1'b1;
      case (ex_op)
         OP_ADD:  alu_res = g_operand[0].val + g_operand[1].val;
         OP_SUB:  alu_res = g_operand[0].val - g_operand[1].val;
         OP_AND:  alu_res = g_operand[0].val & g_operand[1].val;
         OP_OR:   alu_res = g_operand[0].val | g_operand[1].val;
         OP_XOR:  alu_res = g_operand[0].val ^ g_operand[1].val;
         OP_SLL:  alu_res = g_operand[0].val << g_operand[1].val[SH_W-1:0];
         OP_SRL:  alu_res = g_operand[0].val >> g_operand[1].val[SH_W-1:0];
         OP_LDI:  alu_res = DATA_W'(ifex_ins_reg[8:3]);
         default: alu_wr  = 1'b0;
      endcase
      exwb_valid_next = alu_wr && (ex_rd != 3'd0);
   end

   // Fetch and pipeline registers; HALT squashes the next fetch and freezes PC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg         <= '0;
         ifex_ins_reg   <= '0;
         exwb_valid_reg <= 1'b0;
         exwb_reg_reg   <= '0;
         exwb_data_reg  <= '0;
         halted_reg     <= 1'b0;
      end else if (en) begin
         exwb_valid_reg <= exwb_valid_next;
         exwb_reg_reg   <= ex_rd;
         exwb_data_reg  <= alu_res;
         if (ex_is_halt) begin
            ifex_ins_reg <= '0;
            halted_reg   <= 1'b1;
         end else if (!halted_reg) begin
            pc_reg       <= pc_reg + PC_W'(1);
            ifex_ins_reg <= imem_ins;
         end
      end
   end

   // Writes with rd=0 never become valid, so r0 is never written here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) regs_reg[i] <= '0;
      end else if (en && exwb_valid_reg) begin
         regs_reg[exwb_reg_reg] <= exwb_data_reg;
      end
   end

   assign imem_addr = pc_reg;
   assign halted    = halted_reg;
   assign wb_valid  = exwb_valid_reg;
   assign wb_reg    = exwb_reg_reg;
   assign wb_data   = exwb_data_reg;
   assign dbg_data  = (dbg_addr == 3'd0) ? '0 : regs_reg[dbg_addr];

endmodule
